// File: rtl/lapido_pkg.sv
// Shared definitions for the Lapido execute stage: widths, ALU opcodes,
// forwarding-select encodings.
package lapido_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 4;
   localparam int OP_W   = 5;

   localparam logic [OP_W-1:0] ALU_ADD   = 5'b00000;
   localparam logic [OP_W-1:0] ALU_ADDC  = 5'b00001;
   localparam logic [OP_W-1:0] ALU_INCA  = 5'b00010;
   localparam logic [OP_W-1:0] ALU_SUB   = 5'b00011;
   localparam logic [OP_W-1:0] ALU_SUBD  = 5'b00100;
   localparam logic [OP_W-1:0] ALU_DECA  = 5'b00101;
   localparam logic [OP_W-1:0] ALU_LSL   = 5'b00110;
   localparam logic [OP_W-1:0] ALU_ASR   = 5'b00111;
   localparam logic [OP_W-1:0] ALU_ZEROS = 5'b01000;
   localparam logic [OP_W-1:0] ALU_ONES  = 5'b01001;
   localparam logic [OP_W-1:0] ALU_PASSA = 5'b01010;
   localparam logic [OP_W-1:0] ALU_PASSB = 5'b01011;
   localparam logic [OP_W-1:0] ALU_AND   = 5'b01100;
   localparam logic [OP_W-1:0] ALU_OR    = 5'b01101;
   localparam logic [OP_W-1:0] ALU_XOR   = 5'b01110;
   localparam logic [OP_W-1:0] ALU_NOTA  = 5'b01111;
   localparam logic [OP_W-1:0] ALU_SLT   = 5'b10000;

   localparam logic [1:0] FWD_IDEX  = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/ex_hazard_alu_if.sv
// EX-stage bundle: ALU operands/results, forwarding and hazard signals.
// master = pipeline side driving the stage, slave = ex_hazard_alu.
interface ex_hazard_alu_if;

   logic [lapido_pkg::DATA_W-1:0] alu_a;
   logic [lapido_pkg::DATA_W-1:0] alu_b;
   logic [lapido_pkg::OP_W-1:0]   alu_op;
   logic [lapido_pkg::DATA_W-1:0] alu_out;
   logic                          zero;
   logic                          carry;
   logic                          overflow;
   logic [2:0]                    flags_q;

   logic                          ex_mem_regWrite;
   logic                          mem_wb_regWrite;
   logic [lapido_pkg::REG_W-1:0]  ex_mem_registerRD;
   logic [lapido_pkg::REG_W-1:0]  mem_wb_registerRD;
   logic [lapido_pkg::REG_W-1:0]  id_ex_registerA;
   logic [lapido_pkg::REG_W-1:0]  id_ex_registerB;
   logic [1:0]                    forwardA;
   logic [1:0]                    forwardB;

   logic                          id_ex_memRead;
   logic [lapido_pkg::REG_W-1:0]  id_ex_registerRD;
   logic [lapido_pkg::REG_W-1:0]  if_id_registerA;
   logic [lapido_pkg::REG_W-1:0]  if_id_registerB;
   logic                          branch;
   logic                          enablePC;
   logic                          muxSelector;

   modport master (
      output alu_a, alu_b, alu_op,
      output ex_mem_regWrite, mem_wb_regWrite, ex_mem_registerRD, mem_wb_registerRD,
      output id_ex_registerA, id_ex_registerB,
      output id_ex_memRead, id_ex_registerRD, if_id_registerA, if_id_registerB, branch,
      input  alu_out, zero, carry, overflow, flags_q,
      input  forwardA, forwardB, enablePC, muxSelector
   );

   modport slave (
      input  alu_a, alu_b, alu_op,
      input  ex_mem_regWrite, mem_wb_regWrite, ex_mem_registerRD, mem_wb_registerRD,
      input  id_ex_registerA, id_ex_registerB,
      input  id_ex_memRead, id_ex_registerRD, if_id_registerA, if_id_registerB, branch,
      output alu_out, zero, carry, overflow, flags_q,
      output forwardA, forwardB, enablePC, muxSelector
   );

endinterface

// File: rtl/lapido_alu.sv
// Combinational 32-bit ALU. All add/sub variants share one 33-bit adder:
// subtraction is A + ~B + 1, so the adder carry-out doubles as "no borrow".
module lapido_alu
   import lapido_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [OP_W-1:0]   op,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              carry,
   output logic              overflow
);

   logic [DATA_W-1:0] add_y;
   logic              add_cin;
   logic [DATA_W:0]   sum;

   // Select the adder's second operand and carry-in per arithmetic opcode
   always_comb begin
      add_y   = b;
      add_cin = 1'b0;
      unique case (op)
         ALU_ADDC: add_cin = 1'b1;
         ALU_INCA: begin add_y = '0;  add_cin = 1'b1; end
         ALU_SUB:  begin add_y = ~b;  add_cin = 1'b1; end
         ALU_SUBD: add_y = ~b;
         ALU_DECA: add_y = '1;
         default: ;
      endcase
   end

   assign sum = {1'b0, a} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_cin};

   // Result mux and carry/overflow per opcode class
   always_comb begin
      result   = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      unique case (op)
         ALU_ADD, ALU_ADDC, ALU_INCA, ALU_SUB, ALU_SUBD, ALU_DECA: begin
            result   = sum[DATA_W-1:0];
            carry    = sum[DATA_W];
            // operands of equal sign producing a result of the other sign
            overflow = (a[DATA_W-1] == add_y[DATA_W-1]) &&
                       (sum[DATA_W-1] != a[DATA_W-1]);
         end
         ALU_LSL: begin
            result = {a[DATA_W-2:0], 1'b0};
            carry  = a[DATA_W-1];
         end
         ALU_ASR: begin
            result = {a[DATA_W-1], a[DATA_W-1:1]};
            carry  = a[0];
         end
         ALU_ZEROS: result = '0;
         ALU_ONES:  result = '1;
         ALU_PASSA: result = a;
         ALU_PASSB: result = b;
         ALU_AND:   result = a & b;
         ALU_OR:    result = a | b;
         ALU_XOR:   result = a ^ b;
         ALU_NOTA:  result = ~a;
         ALU_SLT:   result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         default:   result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/ex_hazard_alu.sv
// Execute stage core: ALU, operand forwarding select, load-use / branch
// hazard control, and a registered copy of the ALU flags.
module ex_hazard_alu
   import lapido_pkg::*;
(
   input  logic         clock,
   input  logic         reset,
   ex_hazard_alu_if.slave bus
);

   logic [2:0] flags_d, flags_q;
   logic       fwd_unused;

   lapido_alu u_alu (
      .a        (bus.alu_a),
      .b        (bus.alu_b),
      .op       (bus.alu_op),
      .result   (bus.alu_out),
      .zero     (bus.zero),
      .carry    (bus.carry),
      .overflow (bus.overflow)
   );

   // Forwarding: the younger producer (EX/MEM) wins over MEM/WB
   always_comb begin
      bus.forwardA = FWD_IDEX;
      bus.forwardB = FWD_IDEX;
      if (bus.ex_mem_regWrite && bus.ex_mem_registerRD == bus.id_ex_registerA)
         bus.forwardA = FWD_EXMEM;
      else if (bus.mem_wb_regWrite && bus.mem_wb_registerRD == bus.id_ex_registerA)
         bus.forwardA = FWD_MEMWB;
      if (bus.ex_mem_regWrite && bus.ex_mem_registerRD == bus.id_ex_registerB)
         bus.forwardB = FWD_EXMEM;
      else if (bus.mem_wb_regWrite && bus.mem_wb_registerRD == bus.id_ex_registerB)
         bus.forwardB = FWD_MEMWB;
   end

   assign fwd_unused = 1'b0;

   // Hazards: a taken branch flushes decode and lets fetch redirect, which
   // overrides any load-use stall on the (now discarded) decode instruction
   always_comb begin
      bus.enablePC    = 1'b1;
      bus.muxSelector = 1'b0;
      if (bus.branch) begin
         bus.enablePC    = 1'b1;
         bus.muxSelector = 1'b1;
      end else if (bus.id_ex_memRead &&
                   (bus.id_ex_registerRD == bus.if_id_registerA ||
                    bus.id_ex_registerRD == bus.if_id_registerB)) begin
         bus.enablePC    = 1'b0;
         bus.muxSelector = 1'b1;
      end
   end

   // Next flag value is simply the current ALU status
   always_comb begin
      flags_d = {bus.overflow, bus.carry, bus.zero};
   end

   // Flag register, cleared asynchronously
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) flags_q <= 3'b000;
      else        flags_q <= flags_d;
   end

   assign bus.flags_q = flags_q;

endmodule

// File: tb/tb_ex_hazard_alu.sv
// Directed bench for ex_hazard_alu: ALU vectors, forwarding, hazards,
// flag register timing and asynchronous reset.
module tb_ex_hazard_alu;
   import lapido_pkg::*;

   logic clock;
   logic reset;
   int   vectors;
   int   miscompares;

   ex_hazard_alu_if bus_if ();

   ex_hazard_alu dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // drive ALU inputs, settle, check result and {overflow,carry,zero}
   task automatic alu_vec(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_out,
                          input logic [2:0] exp_flags);
      bus_if.alu_op = op;
      bus_if.alu_a  = a;
      bus_if.alu_b  = b;
      #1;
      chk({tag, ".out"}, bus_if.alu_out, exp_out);
      chk({tag, ".flags"}, {29'd0, bus_if.overflow, bus_if.carry, bus_if.zero},
          {29'd0, exp_flags});
   endtask

   task automatic fwd_vec(input string tag, input logic exw, input logic [3:0] exrd,
                          input logic mww, input logic [3:0] mwrd,
                          input logic [3:0] ra, input logic [3:0] rb,
                          input logic [1:0] exp_a, input logic [1:0] exp_b);
      bus_if.ex_mem_regWrite   = exw;
      bus_if.ex_mem_registerRD = exrd;
      bus_if.mem_wb_regWrite   = mww;
      bus_if.mem_wb_registerRD = mwrd;
      bus_if.id_ex_registerA   = ra;
      bus_if.id_ex_registerB   = rb;
      #1;
      chk({tag, ".fwdA"}, {30'd0, bus_if.forwardA}, {30'd0, exp_a});
      chk({tag, ".fwdB"}, {30'd0, bus_if.forwardB}, {30'd0, exp_b});
   endtask

   task automatic haz_vec(input string tag, input logic mr, input logic [3:0] rd,
                          input logic [3:0] ia, input logic [3:0] ib, input logic br,
                          input logic exp_en, input logic exp_mux);
      bus_if.id_ex_memRead    = mr;
      bus_if.id_ex_registerRD = rd;
      bus_if.if_id_registerA  = ia;
      bus_if.if_id_registerB  = ib;
      bus_if.branch           = br;
      #1;
      chk(tag, {30'd0, bus_if.enablePC, bus_if.muxSelector}, {30'd0, exp_en, exp_mux});
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      bus_if.alu_a = '0; bus_if.alu_b = '0; bus_if.alu_op = ALU_ADD;
      bus_if.ex_mem_regWrite = 1'b0; bus_if.mem_wb_regWrite = 1'b0;
      bus_if.ex_mem_registerRD = '0; bus_if.mem_wb_registerRD = '0;
      bus_if.id_ex_registerA = '0; bus_if.id_ex_registerB = '0;
      bus_if.id_ex_memRead = 1'b0; bus_if.id_ex_registerRD = '0;
      bus_if.if_id_registerA = '0; bus_if.if_id_registerB = '0;
      bus_if.branch = 1'b0;
      #1;
      chk("reset.flags_q", {29'd0, bus_if.flags_q}, 32'd0);

      @(negedge clock);
      reset = 1'b1;

      // ALU: flags are {overflow, carry, zero}
      alu_vec("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 3'b100);
      @(posedge clock); #1;
      chk("add_ovf.flags_q", {29'd0, bus_if.flags_q}, 32'd4);
      @(negedge clock);
      alu_vec("sub_eq",  ALU_SUB,  32'd5, 32'd5, 32'h0, 3'b011);
      alu_vec("sub_brw", ALU_SUB,  32'd3, 32'd5, 32'hFFFF_FFFE, 3'b000);
      alu_vec("asr",     ALU_ASR,  32'h8000_0001, 32'h0, 32'hC000_0000, 3'b010);
      alu_vec("lsl",     ALU_LSL,  32'h8000_0001, 32'h0, 32'h0000_0002, 3'b010);
      alu_vec("addc",    ALU_ADDC, 32'd1, 32'd1, 32'd3, 3'b000);
      alu_vec("inca_wr", ALU_INCA, 32'hFFFF_FFFF, 32'h0, 32'h0, 3'b011);
      alu_vec("subd",    ALU_SUBD, 32'd5, 32'd3, 32'd1, 3'b010);
      alu_vec("deca0",   ALU_DECA, 32'd0, 32'h0, 32'hFFFF_FFFF, 3'b000);
      alu_vec("deca_ov", ALU_DECA, 32'h8000_0000, 32'h0, 32'h7FFF_FFFF, 3'b110);
      alu_vec("slt_t",   ALU_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 3'b000);
      alu_vec("slt_f",   ALU_SLT,  32'd1, 32'hFFFF_FFFF, 32'd0, 3'b001);
      alu_vec("xor",     ALU_XOR,  32'hF0F0_1234, 32'hFF00_FFFF, 32'h0FF0_EDCB, 3'b000);
      alu_vec("nota",    ALU_NOTA, 32'h0000_FFFF, 32'h0, 32'hFFFF_0000, 3'b000);
      alu_vec("ones",    ALU_ONES, 32'h0, 32'h0, 32'hFFFF_FFFF, 3'b000);
      alu_vec("passb",   ALU_PASSB, 32'h1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b000);
      alu_vec("undef",   5'b11111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 3'b001);

      // forwarding: {exw, exrd, mww, mwrd, idexA, idexB}
      fwd_vec("fwd_both", 1'b1, 4'd3, 1'b1, 4'd3, 4'd3, 4'd4, FWD_EXMEM, FWD_IDEX);
      fwd_vec("fwd_mw",   1'b0, 4'd3, 1'b1, 4'd3, 4'd3, 4'd4, FWD_MEMWB, FWD_IDEX);
      fwd_vec("fwd_b",    1'b1, 4'd4, 1'b1, 4'd0, 4'd0, 4'd4, FWD_MEMWB, FWD_EXMEM);

      // hazards: {memRead, rd, ifidA, ifidB, branch}
      haz_vec("lu_b",     1'b1, 4'd7, 4'd1, 4'd7, 1'b0, 1'b0, 1'b1);
      haz_vec("lu_miss",  1'b1, 4'd8, 4'd1, 4'd7, 1'b0, 1'b1, 1'b0);
      haz_vec("lu_a",     1'b1, 4'd1, 4'd1, 4'd7, 1'b0, 1'b0, 1'b1);
      haz_vec("no_load",  1'b0, 4'd7, 4'd7, 4'd7, 1'b0, 1'b1, 1'b0);
      haz_vec("br_lu",    1'b1, 4'd7, 4'd1, 4'd7, 1'b1, 1'b1, 1'b1);

      // async reset while flags_q = 111, then release between edges
      @(negedge clock);
      alu_vec("flag111", ALU_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0, 3'b111);
      @(posedge clock); #1;
      chk("flag111.flags_q", {29'd0, bus_if.flags_q}, 32'd7);
      #2 reset = 1'b0;
      #1;
      chk("async_rst.flags_q", {29'd0, bus_if.flags_q}, 32'd0);
      chk("rst_comb.zero", {31'd0, bus_if.zero}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("released.flags_q", {29'd0, bus_if.flags_q}, 32'd0);
      @(posedge clock); #1;
      chk("after_rel.flags_q", {29'd0, bus_if.flags_q}, 32'd7);
      @(negedge clock);
      alu_vec("sub_lt", ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 3'b000);
      @(posedge clock); #1;
      chk("sub_lt.flags_q", {29'd0, bus_if.flags_q}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ex_hazard_alu.md
# ex_hazard_alu

Execute-stage datapath core of the Lapido 5-stage pipeline. It combines three functions:
- the 32-bit ALU;
- the forwarding unit, which picks ALU operand sources from ID/EX, EX/MEM or MEM/WB;
- the hazard detection unit, which stalls on load-use and inserts a bubble on taken branches.

All decisions are combinational except a registered copy of the ALU status flags.

## Interface
Parameters:
- none. Data width is fixed at 32 bits, register index at 4 bits (16 registers), ALU opcode at 5 bits.

Ports:
- clock  in  1  single system clock; the flag register is updated on the rising edge
- reset  in  1  asynchronous, active-low; clears the flag register
- alu_a  in  32  operand A (after the forwarding mux)
- alu_b  in  32  operand B (after the immediate and forwarding muxes)
- alu_op  in  5  operation code
- alu_out  out  32  result
- zero  out  1  alu_out == 0
- carry  out  1  carry/shift-out
- overflow  out  1  signed overflow
- flags_q  out  3  registered {overflow, carry, zero}
- ex_mem_regWrite, mem_wb_regWrite  in  1  writeback enables of the later stages
- ex_mem_registerRD, mem_wb_registerRD  in  4  destination indices
- id_ex_registerA, id_ex_registerB  in  4  source indices in EX
- forwardA, forwardB  out  2  forwarding selects
- id_ex_memRead  in  1  instruction in EX is a load
- id_ex_registerRD  in  4  load destination
- if_id_registerA, if_id_registerB  in  4  sources of the instruction in decode
- branch  in  1  branch taken (resolved in EX)
- enablePC  out  1  1 = PC and IF/ID may advance
- muxSelector  out  1  1 = replace decode control word with a bubble

## Operation
ALU operations (alu_op → result):
- 00000 ADD: A+B
- 00001 ADDC: A+B+1
- 00010 INCA: A+1
- 00011 SUB: A−B
- 00100 SUBD: A−B−1
- 00101 DECA: A−1
- 00110 LSL: A<<1
- 00111 ASR: A>>>1
- 01000 ZEROS: 0
- 01001 ONES: 0xFFFFFFFF
- 01010 PASSA: A
- 01011 PASSB: B
- 01100 AND
- 01101 OR
- 01110 XOR
- 01111 NOTA: ~A
- 10000 SLT: 1 if signed A<B, else 0
- all other codes: result 0, carry=overflow=0

ALU flag rules:
- Arithmetic is computed 33 bits wide; carry = bit 32. For subtraction, carry=1 means no borrow (A ≥ B unsigned).
- overflow = signed overflow of the add/sub actually performed.
- LSL: carry = A[31]. ASR: carry = A[0]. overflow = 0 for both.
- Logic, pass, constant and SLT operations: carry = overflow = 0.
- zero follows alu_out for every opcode.

Forwarding, evaluated independently for A and B:
- 2'b10 when ex_mem_regWrite and ex_mem_registerRD == id_ex_registerX.
- Else 2'b01 when mem_wb_regWrite and mem_wb_registerRD == id_ex_registerX.
- Else 2'b00.
- EX/MEM has priority over MEM/WB. Register 0 is not special.

Hazard detection:
- Load-use: id_ex_memRead and id_ex_registerRD equals if_id_registerA or if_id_registerB → enablePC=0, muxSelector=1.
- branch=1 → muxSelector=1 (flush the decode slot) and enablePC=1. Branch takes precedence over load-use.
- Otherwise enablePC=1, muxSelector=0.

## Timing
- alu_out, zero, carry, overflow, forwardA/B, enablePC and muxSelector are purely combinational, with zero latency, so the branch decision (zero & branch) resolves in the same EX cycle.
- flags_q captures {overflow, carry, zero} at every rising clock edge: one-cycle latency.
- Reset low: flags_q = 3'b000 immediately, asynchronously. Combinational outputs are unaffected by reset.
- Releasing reset between edges: flags_q updates on the next rising edge.
- A load-use stall lasts exactly one cycle. Once the load leaves EX, id_ex_memRead (now a bubble) is 0 and enablePC returns to 1.

## Structure
- Shared package lapido_pkg holds:
  - the ALU opcode localparams (ALU_ADD … ALU_SLT);
  - forwarding encodings FWD_IDEX=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10;
  - the widths.
- One sub-module, lapido_alu, contains the combinational ALU. Forwarding and hazard logic stay inline in the top level, together with the flag register.

## Test plan
- ADD 0x7FFFFFFF + 1 → out 0x80000000, overflow=1, carry=0, zero=0. On the next edge flags_q=3'b100.
- SUB 5−5 → out 0, zero=1, carry=1. SUB 3−5 → out 0xFFFFFFFE, carry=0. ASR 0x80000001 → 0xC0000000, carry=1.
- Forwarding with ex_mem RD=3 and mem_wb RD=3 (both writing), id_ex A=3, B=4 → forwardA=10, forwardB=00. Same case with ex_mem_regWrite=0 → forwardA=01.
- Load-use: id_ex_memRead=1, RD=7, if_id B=7 → enablePC=0, muxSelector=1. Change RD to 8 → 1, 0.
- Branch=1 together with a load-use match → enablePC=1, muxSelector=1.
- Reset asserted mid-run while flags_q=3'b111 → flags_q=000 without waiting for a clock edge. After release, flags_q follows the ALU again.
